// File: rtl/control_unit.sv
// control_unit: Moore sequencer for a 32-bit load/store CPU. Steps through a
// three-cycle fetch (T0-T2) and up to five execute cycles (T3-T7). Each cycle's
// datapath strobes are decoded from the current state and the opcode held in IR.
module control_unit (
   input  logic        clk,
   input  logic        clr,
   input  logic [31:0] IR,
   input  logic        CON_output,
   output logic        PC_out,
   output logic        Zlo_out,
   output logic        Zhi_out,
   output logic        HI_out,
   output logic        LO_out,
   output logic        MDR_out,
   output logic        In_out,
   output logic        C_out,
   output logic        R_out,
   output logic        BAout,
   output logic        PC_rd,
   output logic        MAR_rd,
   output logic        MDR_rd,
   output logic        IR_rd,
   output logic        Y_rd,
   output logic        Zlo_rd,
   output logic        Rin,
   output logic        CONin,
   output logic        Gra,
   output logic        Grb,
   output logic        Grc,
   output logic        IncPC,
   output logic        Read,
   output logic        Write,
   output logic [4:0]  op_sel,
   output logic [15:0] R_wrt,
   output logic        run,
   output logic        illegal
);

   typedef enum logic [3:0] {
      S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
   } state_e;

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_BR   = 5'b10011;
   localparam logic [4:0] OP_JR   = 5'b10100;
   localparam logic [4:0] OP_JAL  = 5'b10101;
   localparam logic [4:0] OP_MFHI = 5'b11000;
   localparam logic [4:0] OP_MFLO = 5'b11001;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   state_e     state_q, state_d;
   logic [4:0] opc;
   logic       is_alu, is_imm, is_mem, is_ld, is_st, is_ldi;
   logic       unused_ir;

   assign opc       = IR[31:27];
   // Register-field fields are consumed by the datapath, not here.
   assign unused_ir = ^IR[26:0];

   assign is_alu = (opc >= 5'b00011) && (opc <= 5'b01011);
   assign is_imm = (opc >= 5'b01100) && (opc <= 5'b01110);
   assign is_ld  = (opc == OP_LD);
   assign is_ldi = (opc == OP_LDI);
   assign is_st  = (opc == OP_ST);
   // ld, ldi and st share the effective-address computation in T3-T4.
   assign is_mem = is_ld || is_ldi || is_st;

   // State register; clr low forces RESET from anywhere, abandoning the instruction.
   always_ff @(posedge clk) begin
      if (!clr) state_q <= S_RESET;
      else      state_q <= state_d;
   end

   // Next-state: instruction length is decided by the opcode at each step.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_RESET: state_d = S_T0;
         S_T0:    state_d = S_T1;
         S_T1:    state_d = S_T2;
         S_T2: begin
            if (opc == OP_NOP)       state_d = S_T0;
            else if (opc == OP_HALT) state_d = S_HALT;
            else                     state_d = S_T3;
         end
         S_T3: state_d = (is_mem || is_alu || is_imm || opc == OP_BR || opc == OP_JAL)
                         ? S_T4 : S_T0;
         S_T4: state_d = (opc == OP_JAL) ? S_T0 : S_T5;
         S_T5: state_d = (is_ld || is_st || opc == OP_BR) ? S_T6 : S_T0;
         S_T6: state_d = (is_ld || is_st) ? S_T7 : S_T0;
         S_T7: state_d = S_T0;
         S_HALT: state_d = S_HALT;
         default: state_d = S_RESET;
      endcase
   end

   // Output decode: everything defaults to 0 and each state raises only its strobes.
   always_comb begin
      PC_out = 1'b0; Zlo_out = 1'b0; Zhi_out = 1'b0; HI_out = 1'b0; LO_out = 1'b0;
      MDR_out = 1'b0; In_out = 1'b0; C_out = 1'b0; R_out = 1'b0; BAout = 1'b0;
      PC_rd = 1'b0; MAR_rd = 1'b0; MDR_rd = 1'b0; IR_rd = 1'b0; Y_rd = 1'b0;
      Zlo_rd = 1'b0; Rin = 1'b0; CONin = 1'b0; Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
      IncPC = 1'b0; Read = 1'b0; Write = 1'b0; op_sel = 5'b00000; R_wrt = 16'h0000;
      run = 1'b0; illegal = 1'b0;
      unique case (state_q)
         S_T0: begin
            run = 1'b1; PC_out = 1'b1; MAR_rd = 1'b1; IncPC = 1'b1; Zlo_rd = 1'b1;
         end
         S_T1: begin
            run = 1'b1; Zlo_out = 1'b1; PC_rd = 1'b1; Read = 1'b1; MDR_rd = 1'b1;
         end
         S_T2: begin
            run = 1'b1; MDR_out = 1'b1; IR_rd = 1'b1;
         end
         S_T3: begin
            run = 1'b1;
            if (is_alu || is_imm) begin
               Grb = 1'b1; R_out = 1'b1; Y_rd = 1'b1;
            end else if (is_mem) begin
               Grb = 1'b1; BAout = 1'b1; Y_rd = 1'b1;
            end else if (opc == OP_BR) begin
               Gra = 1'b1; R_out = 1'b1; CONin = 1'b1;
            end else if (opc == OP_JR) begin
               Gra = 1'b1; R_out = 1'b1; PC_rd = 1'b1;
            end else if (opc == OP_JAL) begin
               // Link: R15 <- PC via the direct write select, not the Gra field.
               PC_out = 1'b1; Rin = 1'b1; R_wrt = 16'h8000;
            end else if (opc == OP_MFHI) begin
               HI_out = 1'b1; Gra = 1'b1; Rin = 1'b1;
            end else if (opc == OP_MFLO) begin
               LO_out = 1'b1; Gra = 1'b1; Rin = 1'b1;
            end else begin
               illegal = 1'b1;
            end
         end
         S_T4: begin
            run = 1'b1;
            if (is_alu) begin
               Grc = 1'b1; R_out = 1'b1; Zlo_rd = 1'b1; op_sel = opc;
            end else if (is_imm) begin
               C_out = 1'b1; Zlo_rd = 1'b1; op_sel = opc;
            end else if (is_mem) begin
               C_out = 1'b1; Zlo_rd = 1'b1; op_sel = OP_ADD;
            end else if (opc == OP_BR) begin
               PC_out = 1'b1; Y_rd = 1'b1;
            end else if (opc == OP_JAL) begin
               Gra = 1'b1; R_out = 1'b1; PC_rd = 1'b1;
            end
         end
         S_T5: begin
            run = 1'b1;
            if (is_alu || is_imm || is_ldi) begin
               Zlo_out = 1'b1; Gra = 1'b1; Rin = 1'b1;
            end else if (is_ld || is_st) begin
               Zlo_out = 1'b1; MAR_rd = 1'b1;
            end else if (opc == OP_BR) begin
               C_out = 1'b1; Zlo_rd = 1'b1; op_sel = OP_ADD;
            end
         end
         S_T6: begin
            run = 1'b1;
            if (is_ld) begin
               Read = 1'b1; MDR_rd = 1'b1;
            end else if (is_st) begin
               Gra = 1'b1; R_out = 1'b1; MDR_rd = 1'b1;
            end else if (opc == OP_BR && CON_output) begin
               Zlo_out = 1'b1; PC_rd = 1'b1;
            end
         end
         S_T7: begin
            run = 1'b1;
            if (is_ld) begin
               MDR_out = 1'b1; Gra = 1'b1; Rin = 1'b1;
            end else if (is_st) begin
               Write = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks instruction sequences one clock at a time
// and compares every output against hand-built expected control words.
module tb_control_unit;
   logic        clk = 1'b0, clr = 1'b0, CON_output = 1'b0;
   logic [31:0] IR = 32'h0;
   logic PC_out, Zlo_out, Zhi_out, HI_out, LO_out, MDR_out, In_out, C_out, R_out, BAout;
   logic PC_rd, MAR_rd, MDR_rd, IR_rd, Y_rd, Zlo_rd, Rin, CONin;
   logic Gra, Grb, Grc, IncPC, Read, Write, run, illegal;
   logic [4:0]  op_sel;
   logic [15:0] R_wrt;

   control_unit dut (
      .clk(clk), .clr(clr), .IR(IR), .CON_output(CON_output),
      .PC_out(PC_out), .Zlo_out(Zlo_out), .Zhi_out(Zhi_out), .HI_out(HI_out),
      .LO_out(LO_out), .MDR_out(MDR_out), .In_out(In_out), .C_out(C_out),
      .R_out(R_out), .BAout(BAout), .PC_rd(PC_rd), .MAR_rd(MAR_rd),
      .MDR_rd(MDR_rd), .IR_rd(IR_rd), .Y_rd(Y_rd), .Zlo_rd(Zlo_rd), .Rin(Rin),
      .CONin(CONin), .Gra(Gra), .Grb(Grb), .Grc(Grc), .IncPC(IncPC),
      .Read(Read), .Write(Write), .op_sel(op_sel), .R_wrt(R_wrt), .run(run),
      .illegal(illegal)
   );

   always #5 clk = ~clk;

   // Control-word bit masks.
   localparam logic [25:0] M_PCO = 26'd1 << 0,  M_ZLO = 26'd1 << 1,  M_ZHI = 26'd1 << 2;
   localparam logic [25:0] M_HI  = 26'd1 << 3,  M_LO  = 26'd1 << 4,  M_MDRO = 26'd1 << 5;
   localparam logic [25:0] M_INO = 26'd1 << 6,  M_CO  = 26'd1 << 7,  M_RO  = 26'd1 << 8;
   localparam logic [25:0] M_BA  = 26'd1 << 9,  M_PCR = 26'd1 << 10, M_MAR = 26'd1 << 11;
   localparam logic [25:0] M_MDR = 26'd1 << 12, M_IRR = 26'd1 << 13, M_Y   = 26'd1 << 14;
   localparam logic [25:0] M_ZR  = 26'd1 << 15, M_RIN = 26'd1 << 16, M_CON = 26'd1 << 17;
   localparam logic [25:0] M_GA  = 26'd1 << 18, M_GB  = 26'd1 << 19, M_GC  = 26'd1 << 20;
   localparam logic [25:0] M_INC = 26'd1 << 21, M_RD  = 26'd1 << 22, M_WR  = 26'd1 << 23;
   localparam logic [25:0] M_RUN = 26'd1 << 24, M_ILL = 26'd1 << 25;

   localparam logic [25:0] F0 = M_RUN | M_PCO | M_MAR | M_INC | M_ZR;
   localparam logic [25:0] F1 = M_RUN | M_ZLO | M_PCR | M_RD | M_MDR;
   localparam logic [25:0] F2 = M_RUN | M_MDRO | M_IRR;

   int errors = 0;
   int checks = 0;

   function automatic logic [25:0] ctl_word();
      return {illegal, run, Write, Read, IncPC, Grc, Grb, Gra, CONin, Rin, Zlo_rd,
              Y_rd, IR_rd, MDR_rd, MAR_rd, PC_rd, BAout, R_out, C_out, In_out,
              MDR_out, LO_out, HI_out, Zhi_out, Zlo_out, PC_out};
   endfunction

   task automatic check(input string tag, input logic [25:0] ec,
                        input logic [4:0] eop, input logic [15:0] ew);
      logic [46:0] obs, exp;
      obs = {ctl_word(), op_sel, R_wrt};
      exp = {ec, eop, ew};
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed ctl=%h op=%b rwrt=%h expected ctl=%h op=%b rwrt=%h",
                tag, obs[46:21], obs[20:16], obs[15:0], ec, eop, ew);
      end
   endtask

   // Advance one clock and check the state the DUT landed in.
   task automatic cyc(input string tag, input logic [25:0] ec,
                      input logic [4:0] eop = 5'b0, input logic [15:0] ew = 16'h0);
      @(posedge clk); #1;
      check(tag, ec, eop, ew);
   endtask

   task automatic fetch12(input string tag);
      cyc({tag, "_T1"}, F1);
      cyc({tag, "_T2"}, F2);
   endtask

   initial begin
      // Reset state
      @(posedge clk); #1;
      check("reset", 26'h0, 5'b0, 16'h0);

      // add R2,R3,R4
      clr = 1'b1; IR = 32'h191A0000;
      cyc("add_T0", F0);
      fetch12("add");
      cyc("add_T3", M_RUN | M_GB | M_RO | M_Y);
      cyc("add_T4", M_RUN | M_GC | M_RO | M_ZR, 5'b00011);
      cyc("add_T5", M_RUN | M_ZLO | M_GA | M_RIN);
      cyc("add_T0b", F0);

      // jal R5
      IR = 32'hAA800000;
      fetch12("jal");
      cyc("jal_T3", M_RUN | M_PCO | M_RIN, 5'b0, 16'h8000);
      cyc("jal_T4", M_RUN | M_GA | M_RO | M_PCR);
      cyc("jal_T0", F0);

      // br, condition false
      IR = 32'h98000000; CON_output = 1'b0;
      fetch12("brn");
      cyc("brn_T3", M_RUN | M_GA | M_RO | M_CON);
      cyc("brn_T4", M_RUN | M_PCO | M_Y);
      cyc("brn_T5", M_RUN | M_CO | M_ZR, 5'b00011);
      cyc("brn_T6", M_RUN);
      cyc("brn_T0", F0);

      // br, condition true
      CON_output = 1'b1;
      fetch12("bry");
      cyc("bry_T3", M_RUN | M_GA | M_RO | M_CON);
      cyc("bry_T4", M_RUN | M_PCO | M_Y);
      cyc("bry_T5", M_RUN | M_CO | M_ZR, 5'b00011);
      cyc("bry_T6", M_RUN | M_ZLO | M_PCR);
      cyc("bry_T0", F0);
      CON_output = 1'b0;

      // st
      IR = 32'h10000000;
      fetch12("st");
      cyc("st_T3", M_RUN | M_GB | M_BA | M_Y);
      cyc("st_T4", M_RUN | M_CO | M_ZR, 5'b00011);
      cyc("st_T5", M_RUN | M_ZLO | M_MAR);
      cyc("st_T6", M_RUN | M_GA | M_RO | M_MDR);
      cyc("st_T7", M_RUN | M_WR);
      cyc("st_T0", F0);

      // addi (immediate)
      IR = 32'h60000000;
      fetch12("addi");
      cyc("addi_T3", M_RUN | M_GB | M_RO | M_Y);
      cyc("addi_T4", M_RUN | M_CO | M_ZR, 5'b01100);
      cyc("addi_T5", M_RUN | M_ZLO | M_GA | M_RIN);
      cyc("addi_T0", F0);

      // ldi
      IR = 32'h08000000;
      fetch12("ldi");
      cyc("ldi_T3", M_RUN | M_GB | M_BA | M_Y);
      cyc("ldi_T4", M_RUN | M_CO | M_ZR, 5'b00011);
      cyc("ldi_T5", M_RUN | M_ZLO | M_GA | M_RIN);
      cyc("ldi_T0", F0);

      // mfhi / mflo
      IR = 32'hC0000000;
      fetch12("mfhi");
      cyc("mfhi_T3", M_RUN | M_HI | M_GA | M_RIN);
      cyc("mfhi_T0", F0);
      IR = 32'hC8000000;
      fetch12("mflo");
      cyc("mflo_T3", M_RUN | M_LO | M_GA | M_RIN);
      cyc("mflo_T0", F0);

      // jr
      IR = 32'hA0000000;
      fetch12("jr");
      cyc("jr_T3", M_RUN | M_GA | M_RO | M_PCR);
      cyc("jr_T0", F0);

      // illegal opcodes 11111 and 01111
      IR = 32'hF8000000;
      fetch12("ill");
      cyc("ill_T3", M_RUN | M_ILL);
      cyc("ill_T0", F0);
      IR = 32'h78000000;
      fetch12("ill2");
      cyc("ill2_T3", M_RUN | M_ILL);
      cyc("ill2_T0", F0);

      // nop: T2 straight back to T0
      IR = 32'hD0000000;
      fetch12("nop");
      cyc("nop_T0", F0);

      // ld, reset asserted while in T6
      IR = 32'h00000000;
      fetch12("ld");
      cyc("ld_T3", M_RUN | M_GB | M_BA | M_Y);
      cyc("ld_T4", M_RUN | M_CO | M_ZR, 5'b00011);
      cyc("ld_T5", M_RUN | M_ZLO | M_MAR);
      cyc("ld_T6", M_RUN | M_RD | M_MDR);
      clr = 1'b0;
      cyc("ld_rst", 26'h0);
      clr = 1'b1;
      cyc("ld_rst_T0", F0);

      // full ld for comparison
      fetch12("ld2");
      cyc("ld2_T3", M_RUN | M_GB | M_BA | M_Y);
      cyc("ld2_T4", M_RUN | M_CO | M_ZR, 5'b00011);
      cyc("ld2_T5", M_RUN | M_ZLO | M_MAR);
      cyc("ld2_T6", M_RUN | M_RD | M_MDR);
      cyc("ld2_T7", M_RUN | M_MDRO | M_GA | M_RIN);
      cyc("ld2_T0", F0);

      // halt: parks with everything low until reset
      IR = 32'hD8000000;
      fetch12("halt");
      for (int i = 0; i < 20; i++) cyc("halt_hold", 26'h0);
      clr = 1'b0;
      cyc("halt_rst", 26'h0);
      clr = 1'b1;
      cyc("halt_T0", F0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed no completion expected finish");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 clk  input  1  single system clock; all state changes on rising edge.
REQ-002 clr  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-003 IR  input  32  instruction register contents; opcode=IR[31:27], Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15].
REQ-004 CON_output  input  1  branch-condition flip-flop from the datapath.
REQ-005 PC_out, Zlo_out, Zhi_out, HI_out, LO_out, MDR_out, In_out, C_out, R_out, BAout  output  1 each  bus-source selects.
REQ-006 PC_rd, MAR_rd, MDR_rd, IR_rd, Y_rd, Zlo_rd, Rin, CONin  output  1 each  register load enables.
REQ-007 Gra, Grb, Grc, IncPC, Read, Write  output  1 each  register-field selects, PC increment, memory strobes.
REQ-008 op_sel  output  5  ALU operation code.
REQ-009 R_wrt  output  16  one-hot direct register write select; used only for the jal link.
REQ-010 run  output  1  high while executing; low in RESET and HALT.
REQ-011 illegal  output  1  one-cycle pulse on an unsupported opcode.

Function
REQ-012 The block SHALL be a Moore FSM; outputs are decoded from state and latched IR only, and every output not listed for a state is 0.
REQ-013 States SHALL be RESET, T0-T7 and HALT; each state lasts exactly one clk.
REQ-014 Fetch: T0 PC_out, MAR_rd, IncPC, Zlo_rd; T1 Zlo_out, PC_rd, Read, MDR_rd; T2 MDR_out, IR_rd.
REQ-015 T2->T3 SHALL occur for supported opcodes; nop (11010) SHALL go T2->T0; halt (11011) SHALL go T2->HALT.
REQ-016 R-type ALU ops (00011-01011): T3 Grb, R_out, Y_rd; T4 Grc, R_out, Zlo_rd, op_sel=IR[31:27]; T5 Zlo_out, Gra, Rin; then T0 (6 cycles total).
REQ-017 Immediate ops (01100-01110): T3 as in REQ-016; T4 C_out, Zlo_rd, op_sel=IR[31:27]; T5 as in REQ-016.
REQ-018 ldi (00001): T3 Grb, BAout, Y_rd; T4 C_out, Zlo_rd, op_sel=00011; T5 Zlo_out, Gra, Rin.
REQ-019 ld (00000): T3-T4 as ldi; T5 Zlo_out, MAR_rd; T6 Read, MDR_rd; T7 MDR_out, Gra, Rin (8 cycles).
REQ-020 st (00010): T3-T5 as ld; T6 Gra, R_out, MDR_rd with Read=0; T7 Write (8 cycles).
REQ-021 br (10011): T3 Gra, R_out, CONin; T4 PC_out, Y_rd; T5 C_out, Zlo_rd, op_sel=00011; T6 Zlo_out and PC_rd only if CON_output=1; then T0.
REQ-022 jr (10100): T3 Gra, R_out, PC_rd; then T0.
REQ-023 jal (10101): T3 PC_out, Rin, R_wrt=16'h8000 (R15 <- PC); T4 Gra, R_out, PC_rd; then T0.
REQ-024 mfhi (11000) / mflo (11001): T3 HI_out / LO_out, Gra, Rin; then T0.
REQ-025 All other opcodes SHALL pulse illegal in T3 and return to T0 with no register, PC or memory side effects.
REQ-026 Read and Write SHALL never be high in the same cycle; at most one bus-source select SHALL be high in any cycle.
REQ-027 HALT SHALL hold all outputs at 0 and remain there until reset.

Reset
REQ-028 clr=0 at a rising edge SHALL force RESET from any state, including mid-instruction; in RESET all outputs, op_sel and R_wrt are 0.
REQ-029 Any in-flight instruction SHALL be abandoned; no Write, Rin or PC_rd asserts in the cycle after reset is sampled.
REQ-030 First rising edge with clr=1 SHALL move RESET->T0.

Verification
REQ-031 IR=0x191A0000 (add R2,R3,R4) -> T3 Grb/Y_rd, T4 Grc/op_sel=00011, T5 Gra/Rin; run=1; back to T0 on cycle 7.
REQ-032 IR=0xAA800000 (jal R5) -> T3 R_wrt=16'h8000 with PC_out, T4 Gra/R_out/PC_rd, then T0.
REQ-033 br with CON_output=0 -> PC_rd never high in T3-T6; with CON_output=1 -> PC_rd high only in T6.
REQ-034 st opcode -> Write high exactly once (T7); Read low throughout T3-T7.
REQ-035 IR=0xD8000000 (halt) -> HALT after T2, run=0 for 20 cycles; clr=0 then 1 -> RESET then T0.
REQ-036 clr=0 during ld T6 -> next cycle RESET, all outputs 0, no Rin in T7.
